cla_pipe_adder: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control. It is the successor to the fixed 8-bit combinational `cla8`. It generalises width and lookahead block size, adds a subtract mode and signed-overflow detection, and registers the datapath so the adder can sit in a streaming arithmetic pipeline under downstream backpressure.

---
 rtl/cla_pkg.sv | 27 ++
 rtl/cla_block.sv | 49 ++++
 rtl/cla_pipe_adder.sv | 149 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: parameter legality,
// block count and the single-step lookahead carry operator.
package cla_pkg;

  // Smallest and largest lookahead block the datapath is built for.
  localparam int CLA_MIN_BLOCK = 2;
  localparam int CLA_MAX_BLOCK = 8;

  // True when the (width, block) pair can be built: block is 2, 4 or 8 and
  // the width is a whole number of blocks.
  function automatic bit cla_legal(int width, int block);
    bit block_ok;
    block_ok = (block == 2) || (block == 4) || (block == 8);
    return block_ok && (width >= block) && ((width % block) == 0);
  endfunction

  // Number of lookahead blocks in a word.
  function automatic int cla_nblk(int width, int block);
    return width / block;
  endfunction

  // Carry out of a group given its generate, propagate and carry in.
  function automatic logic cla_carry(logic g, logic p, logic cin);
    return g | (p & cin);
  endfunction

endpackage

// File: rtl/cla_block.sv
// One lookahead block: group generate/propagate plus both speculative sums and
// the carry into the block's top bit for carry-in 0 and carry-in 1.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic             g,
  output logic             p,
  output logic [BLOCK-1:0] sum0,
  output logic [BLOCK-1:0] sum1,
  output logic             ctop0,
  output logic             ctop1
);

  logic [BLOCK-1:0] bit_g;
  logic [BLOCK-1:0] bit_p;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Run both speculative carry chains through the block in parallel.
  always_comb begin
    logic c0;
    logic c1;
    sum0  = '0;
    sum1  = '0;
    ctop0 = 1'b0;
    ctop1 = 1'b0;
    g     = 1'b0;
    p     = &bit_p;
    c0    = 1'b0;
    c1    = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      if (i == BLOCK - 1) begin
        ctop0 = c0;
        ctop1 = c1;
      end
      sum0[i] = bit_p[i] ^ c0;
      sum1[i] = bit_p[i] ^ c1;
      c0 = cla_carry(bit_g[i], bit_p[i], c0);
      c1 = cla_carry(bit_g[i], bit_p[i], c1);
    end
    g = c0;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow
// control. Stage 1 builds per-block speculative sums, stage 2 resolves the
// block carries and selects the final sum, carry-out and signed overflow.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NB = cla_nblk(WIDTH, BLOCK);

  if (!cla_legal(WIDTH, BLOCK)) begin : g_illegal
    $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of BLOCK, BLOCK must be 2, 4 or 8");
  end

  // Flow-control enables: a stage moves when it is empty or its consumer moves.
  logic s1_en;
  logic s2_en;
  logic s1_valid;
  logic s2_valid;

  assign s2_en     = ~s2_valid | out_ready;
  assign s1_en     = ~s1_valid | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  // Subtraction is a + ~b + 1, so the operand is inverted and carry-in forced.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = b ^ {WIDTH{sub}};
  assign cin_eff = sub | ci;

  logic [NB-1:0]    blk_g;
  logic [NB-1:0]    blk_p;
  logic [WIDTH-1:0] blk_sum0;
  logic [WIDTH-1:0] blk_sum1;
  logic             top_ctop0;
  logic             top_ctop1;

  // Only the most significant block's top-bit carries feed the overflow flag.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    if (k == NB - 1) begin : g_msb
      cla_block #(.BLOCK(BLOCK)) u_block (
        .a     (a[k*BLOCK +: BLOCK]),
        .b     (b_eff[k*BLOCK +: BLOCK]),
        .g     (blk_g[k]),
        .p     (blk_p[k]),
        .sum0  (blk_sum0[k*BLOCK +: BLOCK]),
        .sum1  (blk_sum1[k*BLOCK +: BLOCK]),
        .ctop0 (top_ctop0),
        .ctop1 (top_ctop1)
      );
    end else begin : g_low
      logic ctop0_unused;
      logic ctop1_unused;
      cla_block #(.BLOCK(BLOCK)) u_block (
        .a     (a[k*BLOCK +: BLOCK]),
        .b     (b_eff[k*BLOCK +: BLOCK]),
        .g     (blk_g[k]),
        .p     (blk_p[k]),
        .sum0  (blk_sum0[k*BLOCK +: BLOCK]),
        .sum1  (blk_sum1[k*BLOCK +: BLOCK]),
        .ctop0 (ctop0_unused),
        .ctop1 (ctop1_unused)
      );
    end
  end

  logic [NB-1:0]    s1_g;
  logic [NB-1:0]    s1_p;
  logic [WIDTH-1:0] s1_sum0;
  logic [WIDTH-1:0] s1_sum1;
  logic             s1_ctop0;
  logic             s1_ctop1;
  logic             s1_cin;

  // Stage 1 register: capture block terms whenever the stage is allowed to move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_ctop0 <= 1'b0;
      s1_ctop1 <= 1'b0;
      s1_cin   <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      s1_g     <= blk_g;
      s1_p     <= blk_p;
      s1_sum0  <= blk_sum0;
      s1_sum1  <= blk_sum1;
      s1_ctop0 <= top_ctop0;
      s1_ctop1 <= top_ctop1;
      s1_cin   <= cin_eff;
    end
  end

  logic [NB:0]      blk_c;
  logic [WIDTH-1:0] s_next;
  logic             ovf_next;

  // Stage 2 logic: chain block carries and pick each block's speculative sum.
  always_comb begin
    blk_c    = '0;
    s_next   = '0;
    ovf_next = 1'b0;
    blk_c[0] = s1_cin;
    for (int k = 0; k < NB; k++) begin
      blk_c[k+1] = cla_carry(s1_g[k], s1_p[k], blk_c[k]);
      s_next[k*BLOCK +: BLOCK] = blk_c[k] ? s1_sum1[k*BLOCK +: BLOCK]
                                          : s1_sum0[k*BLOCK +: BLOCK];
    end
    ovf_next = (blk_c[NB-1] ? s1_ctop1 : s1_ctop0) ^ blk_c[NB];
  end

  // Stage 2 register: results hold while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s        <= '0;
      co       <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      s        <= s_next;
      co       <= blk_c[NB];
      ovf      <= ovf_next;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder across several WIDTH/BLOCK choices.
module tb_cla_pipe_adder;

  localparam int NCFG = 5;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        ci;
  logic        sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        done_chk;
  int          checks;
  int          errors;

  function automatic int cfg_width(int i);
    case (i)
      0: return 8;
      1: return 32;
      2: return 8;
      3: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_block(int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 2;
      3: return 8;
      default: return 4;
    endcase
  endfunction

  // Reference result {ovf, co, s} from plain arithmetic on w-bit operands.
  function automatic logic [65:0] ref_model(int w, logic [63:0] av, logic [63:0] bv,
                                            logic civ, logic subv);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    logic [63:0] be;
    logic [63:0] sm;
    logic [64:0] full;
    logic        co_v;
    logic        ov_v;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = av & mask;
    bm   = bv & mask;
    be   = (subv ? ~bm : bm) & mask;
    full = {1'b0, am} + {1'b0, be} + {64'd0, (subv | civ)};
    sm   = full[63:0] & mask;
    co_v = subv ? (am >= bm) : full[w];
    ov_v = (am[w-1] == be[w-1]) && (sm[w-1] != am[w-1]);
    return {ov_v, co_v, sm};
  endfunction

  task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int W = cfg_width(gi);
    localparam int B = cfg_block(gi);

    logic         iready;
    logic         ovalid;
    logic         cout;
    logic         oflow;
    logic [W-1:0] sum;
    logic [65:0]  exp_q[$];

    cla_pipe_adder #(.WIDTH(W), .BLOCK(B)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (iready),
      .a         (a[W-1:0]),
      .b         (b[W-1:0]),
      .ci        (ci),
      .sub       (sub),
      .out_valid (ovalid),
      .out_ready (out_ready),
      .s         (sum),
      .co        (cout),
      .ovf       (oflow)
    );

    always @(negedge rst_n) exp_q.delete();

    // Mid-cycle compare: any valid output must equal the oldest pending result.
    always @(negedge clk) begin : mon
      logic [63:0] sx;
      if (rst_n) begin
        if (ovalid) begin
          sx = '0;
          sx[W-1:0] = sum;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_result_w%0d_b%0d: got s=%h with nothing pending, expected no result",
                     W, B, sx);
          end else begin
            check($sformatf("result_w%0d_b%0d", W, B), {oflow, cout, sx}, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (in_valid && iready) exp_q.push_back(ref_model(W, a, b, ci, sub));
      end
    end

    always @(posedge done_chk) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL drain_w%0d_b%0d: got %0d results outstanding, expected 0",
                 W, B, exp_q.size());
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and hold it until the adder accepts it.
  task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv,
                               input logic civ, input logic subv);
    logic acc;
    acc      = 1'b0;
    a        = av;
    b        = bv;
    ci       = civ;
    sub      = subv;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = g_dut[0].iready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles, expected acceptance");
    end
    in_valid = 1'b0;
  endtask

  // Compare the 8-bit instance against a hand-computed result.
  task automatic checkOutput(input string name, input logic [7:0] es,
                             input logic eco, input logic eovf);
    check({name, "_valid"}, 66'(g_dut[0].ovalid), 66'd1);
    check(name, {g_dut[0].oflow, g_dut[0].cout, 56'd0, g_dut[0].sum},
          {eovf, eco, 56'd0, es});
  endtask

  initial begin : main
    logic [31:0] s_hold;
    checks    = 0;
    errors    = 0;
    done_chk  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    ci        = 1'b0;
    sub       = 1'b0;

    #2;
    check("reset_out8", {g_dut[0].oflow, g_dut[0].cout, 56'd0, g_dut[0].sum}, 66'd0);
    check("reset_flags8", {64'd0, g_dut[0].ovalid, g_dut[0].iready}, 66'd1);
    check("reset_flags64", {64'd0, g_dut[4].ovalid, g_dut[4].iready}, 66'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    check("model_add_ff_01", ref_model(8, 64'hFF, 64'h01, 1'b0, 1'b0), {1'b0, 1'b1, 64'h00});
    check("model_add_7f_01", ref_model(8, 64'h7F, 64'h01, 1'b0, 1'b0), {1'b1, 1'b0, 64'h80});
    check("model_sub_80_01", ref_model(8, 64'h80, 64'h01, 1'b0, 1'b1), {1'b1, 1'b1, 64'h7F});
    check("model_sub_00_01", ref_model(8, 64'h00, 64'h01, 1'b1, 1'b1), {1'b0, 1'b0, 64'hFF});
    check("model_add64_wrap", ref_model(64, '1, 64'h1, 1'b0, 1'b0), {1'b0, 1'b1, 64'h0});

    applyStimulus(64'hFF, 64'h01, 1'b0, 1'b0);
    step();
    checkOutput("add_ff_01_ci0", 8'h00, 1'b1, 1'b0);
    applyStimulus(64'hFF, 64'h01, 1'b1, 1'b0);
    step();
    checkOutput("add_ff_01_ci1", 8'h01, 1'b1, 1'b0);
    applyStimulus(64'h7F, 64'h01, 1'b0, 1'b0);
    step();
    checkOutput("add_7f_01", 8'h80, 1'b0, 1'b1);
    applyStimulus(64'h80, 64'h01, 1'b0, 1'b1);
    step();
    checkOutput("sub_80_01", 8'h7F, 1'b1, 1'b1);
    applyStimulus(64'h00, 64'h01, 1'b1, 1'b1);
    step();
    checkOutput("sub_00_01", 8'hFF, 1'b0, 1'b0);
    repeat (3) step();

    applyStimulus(64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0);
    applyStimulus(64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 1'b0);
    out_ready = 1'b0;
    a         = 64'hDEAD_BEEF;
    b         = 64'h0BAD_F00D;
    ci        = 1'b0;
    sub       = 1'b1;
    in_valid  = 1'b1;
    #1;
    check("bp_in_ready_low", 66'(g_dut[1].iready), 66'd0);
    check("bp_first_result", {g_dut[1].oflow, g_dut[1].cout, 32'd0, g_dut[1].sum},
          {1'b1, 1'b0, 64'h8000_0000});
    s_hold = g_dut[1].sum;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_stable", {33'd0, g_dut[1].ovalid, g_dut[1].sum}, {33'd1, s_hold});
      check("bp_stall_in_ready", 66'(g_dut[1].iready), 66'd0);
    end
    step();
    out_ready = 1'b1;
    applyStimulus(64'hDEAD_BEEF, 64'h0BAD_F00D, 1'b0, 1'b1);
    applyStimulus(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0);
    applyStimulus(64'h0, 64'h8000_0000, 1'b0, 1'b1);
    repeat (4) step();

    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) begin
        a = '1;
        b = 64'h1;
      end else begin
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
      end
      ci       = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      if (i >= 2) check("tput_out_valid", 66'(g_dut[0].ovalid), 66'd1);
      check("tput_in_ready", 66'(g_dut[3].iready), 66'd1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    applyStimulus(64'h7F, 64'h01, 1'b0, 1'b0);
    applyStimulus(64'hFF, 64'h01, 1'b1, 1'b0);
    checkOutput("pre_reset", 8'h80, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out8", {g_dut[0].oflow, g_dut[0].cout, 56'd0, g_dut[0].sum}, 66'd0);
    check("async_reset_flags8", {64'd0, g_dut[0].ovalid, g_dut[0].iready}, 66'd1);
    check("async_reset_out64", {g_dut[4].oflow, g_dut[4].cout, g_dut[4].sum}, 66'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_reset_idle", {64'd0, g_dut[0].ovalid, g_dut[0].iready}, 66'd1);
    end

    done_chk = 1'b1;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
